// File: rtl/traffic_request_conditioner_pkg.sv
// traffic_request_conditioner_pkg: channel state encoding and sensor bit groups
package traffic_request_conditioner_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QUAL  = 3'd1,
        ST_PEND  = 3'd2,
        ST_SERVE = 3'd3,
        ST_REARM = 3'd4
    } ch_state_t;
    localparam int NS_HI  = 7;
    localparam int NS_LO  = 5;
    localparam int PED_HI = 4;
    localparam int PED_LO = 3;
    localparam int EW_HI  = 2;
    localparam int EW_LO  = 0;
endpackage

// File: rtl/traffic_request_conditioner_request_channel.sv
// request_channel: qualifies one synchronized input into a latched request with starvation flag
module request_channel
    import traffic_request_conditioner_pkg::*;
#(
    parameter int QUAL_CYCLES  = 2,
    parameter int MAX_WAIT     = 30,
    parameter int CNT_W        = 8,
    parameter bit NEED_RELEASE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic grant,
    output logic req,
    output logic starve
);
    localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUAL_CYCLES);
    localparam logic [CNT_W-1:0] WMAX = CNT_W'(MAX_WAIT);
    ch_state_t        r_state;
    logic [CNT_W-1:0] r_qcnt;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_req;
    logic             r_starve;
    logic [CNT_W-1:0] w_wcnt_inc;
    assign w_wcnt_inc = (&r_wcnt) ? r_wcnt : r_wcnt + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_qcnt   <= '0;
            r_wcnt   <= '0;
            r_req    <= 1'b0;
            r_starve <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (s) begin
                    r_state <= ST_QUAL;
                    r_qcnt  <= CNT_W'(1);
                end
                ST_QUAL: if (!s) begin
                    r_state <= ST_IDLE;
                    r_qcnt  <= '0;
                end else if (r_qcnt == QMAX) begin
                    r_state  <= ST_PEND;
                    r_qcnt   <= '0;
                    r_wcnt   <= '0;
                    r_req    <= 1'b1;
                    r_starve <= 1'b0;
                end else begin
                    r_qcnt <= r_qcnt + 1'b1;
                end
                ST_PEND: if (grant) begin
                    r_state  <= ST_SERVE;
                    r_wcnt   <= '0;
                    r_req    <= 1'b0;
                    r_starve <= 1'b0;
                end else begin
                    r_wcnt   <= w_wcnt_inc;
                    r_starve <= w_wcnt_inc >= WMAX;
                end
                ST_SERVE: if (!grant) r_state <= NEED_RELEASE ? ST_REARM : ST_IDLE;
                ST_REARM: if (!s) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign req    = r_req;
    assign starve = r_starve;
endmodule

// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner: synchronizes sensor switches and drives three request channels
module traffic_request_conditioner
    import traffic_request_conditioner_pkg::*;
#(
    parameter int QUAL_CYCLES = 2,
    parameter int MAX_WAIT    = 30,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sensor,
    input  logic       grant_ns,
    input  logic       grant_ew,
    input  logic       grant_ped,
    output logic       car_ns,
    output logic       car_ew,
    output logic       ped,
    output logic [2:0] starve
);
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic       w_s_ns;
    logic       w_s_ped;
    logic       w_s_ew;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
        end
    end
    assign w_s_ns  = |r_sync2[NS_HI:NS_LO];
    assign w_s_ped = |r_sync2[PED_HI:PED_LO];
    assign w_s_ew  = |r_sync2[EW_HI:EW_LO];
    request_channel #(
        .QUAL_CYCLES(QUAL_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .NEED_RELEASE(1'b0)
    ) u_ns (
        .clk(clk), .rst(rst), .s(w_s_ns), .grant(grant_ns), .req(car_ns), .starve(starve[2])
    );
    request_channel #(
        .QUAL_CYCLES(QUAL_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .NEED_RELEASE(1'b1)
    ) u_ped (
        .clk(clk), .rst(rst), .s(w_s_ped), .grant(grant_ped), .req(ped), .starve(starve[1])
    );
    request_channel #(
        .QUAL_CYCLES(QUAL_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .NEED_RELEASE(1'b0)
    ) u_ew (
        .clk(clk), .rst(rst), .s(w_s_ew), .grant(grant_ew), .req(car_ew), .starve(starve[0])
    );
endmodule
